// File: rtl/cdb_arbiter.sv
// Round-robin arbiter and registered driver for the common data bus.
// Optional saturating broadcast counter enabled by defining CDB_ARB_BCAST_CNT_EN.
module cdb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int TAG_W   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      cdb_hold,
    output logic [NUM_REQ-1:0]        accepted,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data
`ifdef CDB_ARB_BCAST_CNT_EN
    ,
    output logic [7:0]                bcast_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [NUM_REQ-1:0] acc_q, acc_d;

    logic [NUM_REQ-1:0] eligible;
    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     scan_idx;

    // A station accepted last edge still shows req this cycle, so mask it out.
    always_comb begin
        eligible    = req & ~acc_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (scan_idx >= (PTR_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_found && eligible[scan_idx[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        valid_d = 1'b0;
        tag_d   = '0;
        data_d  = '0;
        acc_d   = '0;
        if (grant_found && !cdb_hold) begin
            valid_d = 1'b1;
            tag_d   = TAG_W'(grant_idx) + TAG_W'(1);
            data_d  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
            acc_d   = NUM_REQ'(1) << grant_idx;
            ptr_d   = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            acc_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            acc_q   <= acc_d;
        end
    end

    assign accepted  = acc_q;
    assign cdb_valid = valid_q;
    assign cdb_tag   = tag_q;
    assign cdb_data  = data_q;

`ifdef CDB_ARB_BCAST_CNT_EN
    logic [7:0] bcast_cnt_q, bcast_cnt_d;

    always_comb begin
        bcast_cnt_d = bcast_cnt_q;
        if (valid_d && bcast_cnt_q != 8'hFF) begin
            bcast_cnt_d = bcast_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcast_cnt_q <= '0;
        end else begin
            bcast_cnt_q <= bcast_cnt_d;
        end
    end

    assign bcast_cnt = bcast_cnt_q;
`endif

endmodule
